// File: rtl/load_store_unit.sv
// load_store_unit: sequences one LDR/STR at a time through a 16-word data
// memory file and returns a writeback packet (Rd data, Rn update, fault).
// Three states: IDLE accepts and computes the address, ACCESS drives the
// memory for one cycle, RESP holds the packet until the writeback stage
// takes it.
module load_store_unit #(
  parameter int MEM_AW = 4,
  parameter int DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [DW-1:0]     req_base,
  input  logic [11:0]       req_offset,
  input  logic              req_pre,
  input  logic              req_up,
  input  logic              req_wb,
  input  logic [DW-1:0]     req_store_data,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_write_data,
  output logic              mem_ldr_str_en,
  output logic              mem_load_en,
  output logic              mem_store_en,
  input  logic [DW-1:0]     mem_read_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_rd_we,
  output logic [3:0]        rsp_rd,
  output logic [DW-1:0]     rsp_rd_data,
  output logic              rsp_rn_we,
  output logic [3:0]        rsp_rn,
  output logic [DW-1:0]     rsp_rn_data,
  output logic              rsp_fault
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Base +/- zero-extended 12-bit offset, wrapping at the data width.
  function automatic logic [DW-1:0] calc_off_addr(input logic [DW-1:0] base,
                                                  input logic [11:0]   offset,
                                                  input logic          up);
    logic [DW-1:0] off_ext;
    off_ext = {{(DW-12){1'b0}}, offset};
    return up ? (base + off_ext) : (base - off_ext);
  endfunction

  // An access faults if it is not word aligned or lies beyond the memory.
  function automatic logic calc_fault(input logic [DW-1:0] ea);
    return (ea[1:0] != 2'b00) || (ea[DW-1:MEM_AW+2] != '0);
  endfunction

  logic [DW-1:0] off_addr_c;
  logic [DW-1:0] ea_c;
  logic          fault_c;
  logic          accept;

  // Request fields latched at accept, then the word read during ACCESS.
  logic              load_p0;
  logic              pre_p0;
  logic              wb_p0;
  logic              fault_p0;
  logic [3:0]        rd_p0;
  logic [3:0]        rn_p0;
  logic [DW-1:0]     store_data_p0;
  logic [DW-1:0]     off_addr_p0;
  logic [MEM_AW-1:0] maddr_p0;
  logic [DW-1:0]     rd_data_p1;

  assign off_addr_c = calc_off_addr(req_base, req_offset, req_up);
  assign ea_c       = req_pre ? off_addr_c : req_base;
  assign fault_c    = calc_fault(ea_c);
  assign accept     = (state == IDLE) && req_valid;

  // State register; reset returns to IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: latch the request and its address/fault decision on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_p0       <= 1'b0;
      pre_p0        <= 1'b0;
      wb_p0         <= 1'b0;
      fault_p0      <= 1'b0;
      rd_p0         <= '0;
      rn_p0         <= '0;
      store_data_p0 <= '0;
      off_addr_p0   <= '0;
      maddr_p0      <= '0;
    end else if (accept) begin
      load_p0       <= req_load;
      pre_p0        <= req_pre;
      wb_p0         <= req_wb;
      fault_p0      <= fault_c;
      rd_p0         <= req_rd;
      rn_p0         <= req_rn;
      store_data_p0 <= req_store_data;
      off_addr_p0   <= off_addr_c;
      maddr_p0      <= ea_c[MEM_AW+1:2];
    end
  end

  // Stage p1: capture the memory word at the end of ACCESS (stores return 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_p1 <= '0;
    end else if (accept) begin
      rd_data_p1 <= '0;
    end else if (state == ACCESS) begin
      rd_data_p1 <= load_p0 ? mem_read_data : '0;
    end
  end

  // Next-state and all outputs; response fields read 0 outside RESP.
  always_comb begin
    state_nxt      = state;
    req_ready      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    mem_ldr_str_en = 1'b0;
    mem_load_en    = 1'b0;
    mem_store_en   = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rd_we      = 1'b0;
    rsp_rd         = '0;
    rsp_rd_data    = '0;
    rsp_rn_we      = 1'b0;
    rsp_rn         = '0;
    rsp_rn_data    = '0;
    rsp_fault      = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = fault_c ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        mem_ldr_str_en = 1'b1;
        mem_load_en    = load_p0;
        mem_store_en   = !load_p0;
        mem_addr       = maddr_p0;
        mem_write_data = store_data_p0;
        state_nxt      = RESP;
      end
      RESP: begin
        rsp_valid   = 1'b1;
        rsp_rd_we   = load_p0 && !fault_p0;
        rsp_rd      = rd_p0;
        rsp_rd_data = rd_data_p1;
        // A load into its own base register keeps the loaded value.
        rsp_rn_we   = (!pre_p0 || wb_p0) && !fault_p0 &&
                      !(load_p0 && (rd_p0 == rn_p0));
        rsp_rn      = rn_p0;
        rsp_rn_data = off_addr_p0;
        rsp_fault   = fault_p0;
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
